// File: rtl/id_decode_pipe_if.sv
// Handshake and payload bundle for the decode stage.
// The slave side is the decode stage itself; the master side is the
// surrounding pipeline: the IF/ID register, the EX stage and the hazard source.
interface id_decode_pipe_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
);
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         inst;
    logic [XLEN-1:0]     pc;
    logic                flush;
    logic                ex_mem_read;
    logic [RADDR_W-1:0]  ex_rd;
    logic                out_valid;
    logic                out_ready;
    logic [12:0]         out_controls;
    logic [1:0]          out_inst_size;
    logic                out_is_signed;
    logic [XLEN-1:0]     out_imm;
    logic [XLEN-1:0]     out_branch;
    logic [XLEN-1:0]     out_pc;
    logic [RADDR_W-1:0]  out_rs1;
    logic [RADDR_W-1:0]  out_rs2;
    logic [RADDR_W-1:0]  out_rd;
    logic [CNT_W-1:0]    stall_count;

    modport master (
        output in_valid, inst, pc, flush, ex_mem_read, ex_rd, out_ready,
        input  in_ready, out_valid, out_controls, out_inst_size, out_is_signed,
               out_imm, out_branch, out_pc, out_rs1, out_rs2, out_rd, stall_count
    );

    modport slave (
        input  in_valid, inst, pc, flush, ex_mem_read, ex_rd, out_ready,
        output in_ready, out_valid, out_controls, out_inst_size, out_is_signed,
               out_imm, out_branch, out_pc, out_rs1, out_rs2, out_rd, stall_count
    );
endinterface

// File: rtl/id_decode_pipe.sv
// Decode stage of the 32I core with an ID/EX output register.
// Instruction decode (control word and immediate) is combinational from inst
// and is captured into the ID/EX register when the stage accepts.
// Load-use hazards hold the input and insert a bubble; a flush from EX kills
// the held instruction and refuses the incoming one.
//
// out_controls = {mem_read, mem_write, alu_src_a, alu_src_b,
//                 mem_to_reg[1:0], alu_op[3:0], reg_write, jump[1:0]}
//   alu_op    : 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA,
//               8 OR, 9 AND, 10 pass operand B
//   mem_to_reg: 0 ALU result, 1 load data, 2 pc+4
//   jump      : 0 none, 1 JAL, 2 JALR
//   alu_src_a : 1 selects pc (AUIPC, JAL); alu_src_b: 1 selects the immediate
module id_decode_pipe #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic           clk,
    input  logic           reset,
    id_decode_pipe_if.slave bus
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    // ALU operation for register and immediate arithmetic; SUB exists only
    // for the register form, bit 30 picks SRA over SRL in both forms.
    function automatic logic [3:0] arith_alu(input logic [2:0] f3,
                                             input logic b30,
                                             input logic is_reg);
        logic [3:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000:  op = (is_reg && b30) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = b30 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Control word for one instruction; unknown opcodes decode to all zeros.
    function automatic logic [12:0] ctrl_of(input logic [31:0] ins);
        logic       mr, mw, asrc, bsrc, rw;
        logic [1:0] m2r, jmp;
        logic [3:0] alu;
        mr = 1'b0; mw = 1'b0; asrc = 1'b0; bsrc = 1'b0; rw = 1'b0;
        m2r = 2'd0; jmp = 2'd0; alu = ALU_ADD;
        case (ins[6:0])
            OPC_OP:     begin rw = 1'b1; alu = arith_alu(ins[14:12], ins[30], 1'b1); end
            OPC_OP_IMM: begin rw = 1'b1; bsrc = 1'b1; alu = arith_alu(ins[14:12], ins[30], 1'b0); end
            OPC_LOAD:   begin mr = 1'b1; bsrc = 1'b1; m2r = 2'd1; rw = 1'b1; end
            OPC_STORE:  begin mw = 1'b1; bsrc = 1'b1; end
            OPC_BRANCH: begin
                case (ins[14:13])
                    2'b10:   alu = ALU_SLT;
                    2'b11:   alu = ALU_SLTU;
                    default: alu = ALU_SUB;
                endcase
            end
            OPC_LUI:    begin bsrc = 1'b1; rw = 1'b1; alu = ALU_PASSB; end
            OPC_AUIPC:  begin asrc = 1'b1; bsrc = 1'b1; rw = 1'b1; end
            OPC_JAL:    begin asrc = 1'b1; rw = 1'b1; m2r = 2'd2; jmp = 2'd1; end
            OPC_JALR:   begin bsrc = 1'b1; rw = 1'b1; m2r = 2'd2; jmp = 2'd2; end
            default:    ;
        endcase
        return {mr, mw, asrc, bsrc, m2r, alu, rw, jmp};
    endfunction

    // Sign-extended immediate for every format; formats without one give 0.
    function automatic logic signed [31:0] imm_of(input logic [31:0] ins);
        logic signed [31:0] v;
        v = '0;
        case (ins[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                v = {{20{ins[31]}}, ins[31:20]};
            OPC_STORE:
                v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            OPC_BRANCH:
                v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                v = {ins[31:12], 12'b0};
            OPC_JAL:
                v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default:
                v = '0;
        endcase
        return v;
    endfunction

    logic [6:0]          opcode;
    logic [12:0]         dec_ctrl;
    logic [1:0]          dec_size;
    logic                dec_signed;
    logic signed [31:0]  dec_sext;
    logic [XLEN-1:0]     dec_imm_x;
    logic [XLEN-1:0]     dec_imm;
    logic [XLEN-1:0]     dec_branch;
    logic [RADDR_W-1:0]  dec_rs1, dec_rs2, dec_rd;
    logic                is_shift_imm, is_mem;
    logic                uses_rs1, uses_rs2;
    logic                hazard, advance, accept;

    logic                valid_q, valid_d;
    logic [12:0]         ctrl_q, ctrl_d;
    logic [1:0]          size_q, size_d;
    logic                signed_q, signed_d;
    logic [XLEN-1:0]     imm_q, imm_d;
    logic [XLEN-1:0]     branch_q, branch_d;
    logic [XLEN-1:0]     pc_q, pc_d;
    logic [RADDR_W-1:0]  rs1_q, rs1_d;
    logic [RADDR_W-1:0]  rs2_q, rs2_d;
    logic [RADDR_W-1:0]  rd_q, rd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    assign opcode       = bus.inst[6:0];
    assign dec_ctrl     = ctrl_of(bus.inst);
    assign is_mem       = (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    assign dec_size     = is_mem ? bus.inst[13:12] : 2'd0;
    assign dec_signed   = (opcode == OPC_LOAD) && !bus.inst[14];
    assign dec_sext     = imm_of(bus.inst);
    assign dec_imm_x    = XLEN'(dec_sext);
    // Shift-immediates carry a shamt in the immediate field, not a signed value.
    assign is_shift_imm = (opcode == OPC_OP_IMM) && (bus.inst[13:12] == 2'b01);
    assign dec_imm      = is_shift_imm ? XLEN'(bus.inst[24:20]) : dec_imm_x;
    assign dec_branch   = bus.pc + dec_imm_x;
    assign dec_rs1      = RADDR_W'(bus.inst[19:15]);
    assign dec_rs2      = RADDR_W'(bus.inst[24:20]);
    assign dec_rd       = RADDR_W'(bus.inst[11:7]);

    assign uses_rs1 = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
    assign uses_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);

    // in_valid gates the hazard so an idle or undefined inst cannot stall.
    assign hazard  = bus.in_valid && bus.ex_mem_read && (bus.ex_rd != '0) &&
                     ((uses_rs1 && (dec_rs1 == bus.ex_rd)) ||
                      (uses_rs2 && (dec_rs2 == bus.ex_rd)));
    assign advance = !valid_q || bus.out_ready;
    assign accept  = bus.in_valid && bus.in_ready;

    assign bus.in_ready      = advance && !hazard && !bus.flush;
    assign bus.out_valid     = valid_q;
    assign bus.out_controls  = ctrl_q;
    assign bus.out_inst_size = size_q;
    assign bus.out_is_signed = signed_q;
    assign bus.out_imm       = imm_q;
    assign bus.out_branch    = branch_q;
    assign bus.out_pc        = pc_q;
    assign bus.out_rs1       = rs1_q;
    assign bus.out_rs2       = rs2_q;
    assign bus.out_rd        = rd_q;
    assign bus.stall_count   = cnt_q;

    // ID/EX next state: flush kills, accept loads, advance bubbles, else hold.
    always_comb begin
        valid_d  = valid_q;
        ctrl_d   = ctrl_q;
        size_d   = size_q;
        signed_d = signed_q;
        imm_d    = imm_q;
        branch_d = branch_q;
        pc_d     = pc_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            ctrl_d   = dec_ctrl;
            size_d   = dec_size;
            signed_d = dec_signed;
            imm_d    = dec_imm;
            branch_d = dec_branch;
            pc_d     = bus.pc;
            rs1_d    = dec_rs1;
            rs2_d    = dec_rs2;
            rd_d     = dec_rd;
        end else if (advance) begin
            valid_d = 1'b0;
        end
        if (hazard && advance && !bus.flush && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // ID/EX register and stall counter; reset clears everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            imm_q    <= '0;
            branch_q <= '0;
            pc_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            imm_q    <= imm_d;
            branch_q <= branch_d;
            pc_q     <= pc_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
